// File: rtl/fwd_hazard_unit.sv
// EX-stage forwarding selects plus a per-register latency scoreboard that stalls ID.
// Optional stall-cycle performance counter: define HZ_PERF_CNT_EN.
module fwd_hazard_unit #(
  parameter int RIDX_W  = 5,
  parameter int NSRC    = 2,
  parameter int MAX_LAT = 4,
  parameter int LAT_W   = $clog2(MAX_LAT + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  input  logic [NSRC*RIDX_W-1:0] id_src,
  input  logic [NSRC-1:0]        id_src_used,
  input  logic [RIDX_W-1:0]      id_dest,
  input  logic                   id_wen,
  input  logic [LAT_W-1:0]       id_lat,
  input  logic                   flush,
  input  logic [NSRC*RIDX_W-1:0] ex_src,
  input  logic [RIDX_W-1:0]      ex_mem_dest,
  input  logic                   ex_mem_wen,
  input  logic [RIDX_W-1:0]      mem_wb_dest,
  input  logic                   mem_wb_wen,
`ifdef HZ_PERF_CNT_EN
  input  logic                   perf_clr,
  output logic [31:0]            stall_cycles,
`endif
  output logic                   stall,
  output logic [2*NSRC-1:0]      fwd_sel
);

  localparam int NREG = 2 ** RIDX_W;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  // EX/MEM holds the younger value, so it wins over MEM/WB.
  function automatic fwd_sel_e resolve_fwd(input logic [RIDX_W-1:0] s);
    if (s == '0)                                return FWD_RF;
    else if (ex_mem_wen && (ex_mem_dest == s))  return FWD_MEM;
    else if (mem_wb_wen && (mem_wb_dest == s))  return FWD_WB;
    else                                        return FWD_RF;
  endfunction

  logic [LAT_W-1:0] cnt_q [NREG];
  logic [LAT_W-1:0] cnt_d [NREG];
  logic [LAT_W-1:0] lat_clamped;
  logic             hazard;
  logic             issue;
  logic             alloc;

  // ---------------------------------------------------------------------------
  // Forwarding: each operand resolves on its own.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; a missing default would infer a latch.
    fwd_sel = '0;
    for (int k = 0; k < NSRC; k++) begin
      fwd_sel[2*k +: 2] = rst_n ? resolve_fwd(ex_src[k*RIDX_W +: RIDX_W]) : FWD_RF;
    end
  end

  // ---------------------------------------------------------------------------
  // Stall: a counter of 1 means the producer reaches a forwarding path in time.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [RIDX_W-1:0] src_k;
    hazard = 1'b0;
    src_k  = '0;
    for (int k = 0; k < NSRC; k++) begin
      src_k = id_src[k*RIDX_W +: RIDX_W];
      if (id_src_used[k] && (src_k != '0) && (cnt_q[src_k] > LAT_W'(1))) begin
        hazard = 1'b1;
      end
    end
  end

  assign stall       = rst_n && id_valid && !flush && hazard;
  assign issue       = id_valid && !stall && !flush;
  assign alloc       = issue && id_wen && (id_lat != '0) && (id_dest != '0);
  assign lat_clamped = (id_lat > LAT_W'(MAX_LAT)) ? LAT_W'(MAX_LAT) : id_lat;

  // ---------------------------------------------------------------------------
  // Scoreboard next state: a new issue overrides the running countdown.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (r == 0) begin
        cnt_d[r] = '0;
      end else if (alloc && (id_dest == RIDX_W'(r))) begin
        cnt_d[r] = lat_clamped;
      end else if (cnt_q[r] != '0) begin
        cnt_d[r] = cnt_q[r] - LAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this register array is reset because stall is decoded from it;
      // stale counters after reset would hold the pipeline for no reason.
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every counter
      // updates from the same pre-edge values.
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

`ifdef HZ_PERF_CNT_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] stall_cycles_d;

  // Clear wins over increment; the count saturates instead of wrapping.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (perf_clr) begin
      stall_cycles_d = '0;
    end else if (stall && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed scenarios plus randomized
// traffic against a ready-time reference model.
module tb_fwd_hazard_unit;

  localparam int RIDX_W  = 5;
  localparam int NSRC    = 2;
  localparam int MAX_LAT = 4;
  localparam int LAT_W   = $clog2(MAX_LAT + 1);
  localparam int NREG    = 2 ** RIDX_W;

  logic                   clk;
  logic                   rst_n;
  logic                   id_valid;
  logic [NSRC*RIDX_W-1:0] id_src;
  logic [NSRC-1:0]        id_src_used;
  logic [RIDX_W-1:0]      id_dest;
  logic                   id_wen;
  logic [LAT_W-1:0]       id_lat;
  logic                   flush;
  logic [NSRC*RIDX_W-1:0] ex_src;
  logic [RIDX_W-1:0]      ex_mem_dest;
  logic                   ex_mem_wen;
  logic [RIDX_W-1:0]      mem_wb_dest;
  logic                   mem_wb_wen;
  logic                   stall;
  logic [2*NSRC-1:0]      fwd_sel;

  logic [3*RIDX_W-1:0]    id_src3;
  logic [2:0]             id_src_used3;
  logic [3*RIDX_W-1:0]    ex_src3;
  logic                   stall3;
  logic [5:0]             fwd_sel3;

`ifdef HZ_PERF_CNT_EN
  logic                   perf_clr;
  logic [31:0]            stall_cycles;
  logic [31:0]            stall_cycles3;
`endif

  fwd_hazard_unit #(.RIDX_W(RIDX_W), .NSRC(NSRC), .MAX_LAT(MAX_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(id_src),
    .id_src_used(id_src_used), .id_dest(id_dest), .id_wen(id_wen),
    .id_lat(id_lat), .flush(flush), .ex_src(ex_src),
    .ex_mem_dest(ex_mem_dest), .ex_mem_wen(ex_mem_wen),
    .mem_wb_dest(mem_wb_dest), .mem_wb_wen(mem_wb_wen),
`ifdef HZ_PERF_CNT_EN
    .perf_clr(perf_clr), .stall_cycles(stall_cycles),
`endif
    .stall(stall), .fwd_sel(fwd_sel)
  );

  fwd_hazard_unit #(.RIDX_W(RIDX_W), .NSRC(3), .MAX_LAT(MAX_LAT)) dut3 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(id_src3),
    .id_src_used(id_src_used3), .id_dest(id_dest), .id_wen(id_wen),
    .id_lat(id_lat), .flush(flush), .ex_src(ex_src3),
    .ex_mem_dest(ex_mem_dest), .ex_mem_wen(ex_mem_wen),
    .mem_wb_dest(mem_wb_dest), .mem_wb_wen(mem_wb_wen),
`ifdef HZ_PERF_CNT_EN
    .perf_clr(perf_clr), .stall_cycles(stall_cycles3),
`endif
    .stall(stall3), .fwd_sel(fwd_sel3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a producer issued in cycle t with latency L has its
  // result forwardable for a consumer in EX from cycle t+L onward.
  int   cycle;
  int   ready_at [NREG];
  int   perf_model;
  logic obs_stall;

  function automatic logic model_stall();
    logic [RIDX_W-1:0] s;
    if (!rst_n || !id_valid || flush) return 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      s = id_src[k*RIDX_W +: RIDX_W];
      if (id_src_used[k] && s != 0 && cycle < ready_at[s]) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [2*NSRC-1:0] model_fwd();
    logic [RIDX_W-1:0] s;
    logic [2*NSRC-1:0] r;
    r = '0;
    if (!rst_n) return r;
    for (int k = 0; k < NSRC; k++) begin
      s = ex_src[k*RIDX_W +: RIDX_W];
      if (s == 0)                              r[2*k +: 2] = 2'b00;
      else if (ex_mem_wen && ex_mem_dest == s) r[2*k +: 2] = 2'b10;
      else if (mem_wb_wen && mem_wb_dest == s) r[2*k +: 2] = 2'b01;
      else                                     r[2*k +: 2] = 2'b00;
    end
    return r;
  endfunction

  // Compare outputs for the current inputs, update the model, advance one edge.
  task automatic tick();
    logic exp_stall;
    int   lat;
    #3;
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) ready_at[r] = 0;
      perf_model = 0;
    end
    exp_stall = model_stall();
    obs_stall = stall;
    check("stall", 32'(stall), 32'(exp_stall));
    check("fwd_sel", 32'(fwd_sel), 32'(model_fwd()));
`ifdef HZ_PERF_CNT_EN
    check("stall_cycles", stall_cycles, 32'(perf_model));
`endif
    if (rst_n) begin
      if (id_valid && !exp_stall && !flush && id_wen && id_dest != 0 && id_lat != 0) begin
        lat = (int'(id_lat) > MAX_LAT) ? MAX_LAT : int'(id_lat);
        ready_at[id_dest] = cycle + lat;
      end
`ifdef HZ_PERF_CNT_EN
      if (perf_clr) perf_model = 0;
      else if (exp_stall) perf_model++;
`endif
    end
    @(posedge clk);
    cycle++;
    #1;
  endtask

  task automatic issue_prod(input logic [RIDX_W-1:0] dest, input logic [LAT_W-1:0] lat);
    id_valid = 1'b1; id_src_used = '0; id_dest = dest; id_wen = 1'b1;
    id_lat = lat; flush = 1'b0;
    tick();
  endtask

  // Hold a reader of src in ID until it issues; return the stall cycles seen.
  task automatic measure_stalls(input logic [RIDX_W-1:0] src, output int n);
    n = 0;
    id_valid = 1'b1; id_src = {RIDX_W'(0), src}; id_src_used = 2'b01;
    id_wen = 1'b0; id_dest = '0; id_lat = LAT_W'(1); flush = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (!obs_stall) break;
      n++;
    end
    id_valid = 1'b0; id_src_used = '0;
  endtask

  int n_st;

  initial begin
    cycle = 0; perf_model = 0;
    for (int r = 0; r < NREG; r++) ready_at[r] = 0;
    rst_n = 1'b0; id_valid = 1'b1; id_src = {5'd3, 5'd3}; id_src_used = 2'b11;
    id_dest = '0; id_wen = 1'b0; id_lat = '0; flush = 1'b0;
    ex_src = {5'd3, 5'd3}; ex_mem_dest = 5'd3; ex_mem_wen = 1'b1;
    mem_wb_dest = 5'd3; mem_wb_wen = 1'b1;
    id_src3 = '0; id_src_used3 = '0; ex_src3 = '0;
`ifdef HZ_PERF_CNT_EN
    perf_clr = 1'b0;
`endif
    #2;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_fwd_sel", 32'(fwd_sel), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    id_valid = 1'b0;

    // Forwarding priority and x0 exclusion.
    #1 check("fwd_both", 32'(fwd_sel), 32'b1010);
    ex_mem_wen = 1'b0;
    #1 check("fwd_wb_only", 32'(fwd_sel), 32'b0101);
    ex_mem_wen = 1'b1; ex_src = '0;
    #1 check("fwd_x0", 32'(fwd_sel), 32'b0000);
    ex_src = {5'd4, 5'd3}; mem_wb_dest = 5'd4;
    tick();
    check("fwd_mixed", 32'(fwd_sel), 32'b0110);
    ex_mem_wen = 1'b0; mem_wb_wen = 1'b0;

    // Producer latencies.
    issue_prod(5'd7, 3'd2);  measure_stalls(5'd7, n_st);  check("load_use", n_st, 1);
    issue_prod(5'd8, 3'd1);  measure_stalls(5'd8, n_st);  check("alu_dep", n_st, 0);
    issue_prod(5'd9, 3'd3);  measure_stalls(5'd9, n_st);  check("mul_lat", n_st, 2);
    issue_prod(5'd10, 3'd7); measure_stalls(5'd10, n_st); check("lat_clamp", n_st, 3);
    issue_prod(5'd0, 3'd3);  measure_stalls(5'd0, n_st);  check("x0_dest", n_st, 0);

    // Flushed reader must not stall nor allocate its destination.
    issue_prod(5'd9, 3'd3);
    id_valid = 1'b1; id_src = {5'd0, 5'd9}; id_src_used = 2'b01;
    id_dest = 5'd12; id_wen = 1'b1; id_lat = 3'd3; flush = 1'b1;
    tick();
    check("flush_stall", 32'(obs_stall), 32'd0);
    measure_stalls(5'd12, n_st); check("flush_no_alloc", n_st, 0);

    // Reset while stalled.
    issue_prod(5'd5, 3'd3);
    id_valid = 1'b1; id_src = {5'd0, 5'd5}; id_src_used = 2'b01;
    id_wen = 1'b0; flush = 1'b0;
    #1 check("pre_rst_stall", 32'(stall), 32'd1);
    rst_n = 1'b0;
    #1 check("mid_rst_stall", 32'(stall), 32'd0);
    tick();
    rst_n = 1'b1;
    measure_stalls(5'd5, n_st); check("post_rst", n_st, 0);

    // Three-operand instance, fresh from reset: src2 waits on a load.
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    issue_prod(5'd7, 3'd2);
    id_valid = 1'b1; id_wen = 1'b0; id_src_used = '0;
    id_src3 = {5'd7, 5'd2, 5'd1}; id_src_used3 = 3'b111;
    ex_src3 = {5'd3, 5'd0, 5'd4}; ex_mem_dest = 5'd3; ex_mem_wen = 1'b1;
    mem_wb_dest = 5'd4; mem_wb_wen = 1'b1;
    #1 check("nsrc3_stall", 32'(stall3), 32'd1);
    check("nsrc3_fwd", 32'(fwd_sel3), 32'b100001);
    id_src_used3 = 3'b011;
    #1 check("nsrc3_unused", 32'(stall3), 32'd0);
    tick();
    id_src_used3 = '0;

    // Randomized traffic over a small register window to provoke hazards.
    for (int i = 0; i < 3000; i++) begin
      rst_n       = ($urandom_range(0, 199) != 0);
      id_valid    = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < NSRC; k++) begin
        id_src[k*RIDX_W +: RIDX_W] = RIDX_W'($urandom_range(0, 7));
        ex_src[k*RIDX_W +: RIDX_W] = RIDX_W'($urandom_range(0, 7));
      end
      id_src_used = NSRC'($urandom);
      id_dest     = RIDX_W'($urandom_range(0, 7));
      id_wen      = 1'($urandom);
      id_lat      = LAT_W'($urandom);
      flush       = ($urandom_range(0, 9) == 0);
      ex_mem_dest = RIDX_W'($urandom_range(0, 7));
      ex_mem_wen  = 1'($urandom);
      mem_wb_dest = RIDX_W'($urandom_range(0, 7));
      mem_wb_wen  = 1'($urandom);
`ifdef HZ_PERF_CNT_EN
      perf_clr    = ($urandom_range(0, 299) == 0);
`endif
      tick();
    end
    rst_n = 1'b1;

`ifdef HZ_PERF_CNT_EN
    id_valid = 1'b0; perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    tick();
    check("perf_clr", stall_cycles, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
